fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_fd_latch.sv | 30 +++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared widths, bubble encoding and fetch FSM state encoding for the fetch stage.
package fetch_stage_pkg;

    localparam int IADDR_W = 12;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HOLD   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// F/D pipeline latch: load on enable, flush to the bubble word, flush wins over load.
module fd_latch
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               flush,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [IADDR_W-1:0] d_next,
    output logic [INSTR_W-1:0] q_instr,
    output logic [IADDR_W-1:0] q_next
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_instr <= NOP_WORD;
            q_next  <= '0;
        end else if (flush) begin
            q_instr <= NOP_WORD;
            q_next  <= '0;
        end else if (en) begin
            q_instr <= d_instr;
            q_next  <= d_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing against a one-cycle-latency imem, stall/redirect handling.
//
//   state  | meaning
//   RUN    | word returning on q_imem belongs to req_pc and is live
//   SQUASH | word returning on q_imem is stale and must be dropped
//   HOLD   | hold_instr keeps a live word until the stall releases
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [IADDR_W-1:0] RESET_PC = 12'h000,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] q_imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [IADDR_W-1:0] redirect_target,
    output logic [IADDR_W-1:0] address_imem,
    output logic [INSTR_W-1:0] q_imem_fd,
    output logic [IADDR_W-1:0] next_iaddr_fd,
    output logic [15:0]        bubble_count
);

    fetch_state_e       state;
    logic [IADDR_W-1:0] pc;
    logic [IADDR_W-1:0] req_pc;
    logic [INSTR_W-1:0] hold_instr;

    logic               fd_en;
    logic               fd_flush;
    logic               bubble;
    logic [INSTR_W-1:0] fd_d_instr;

    always_comb begin
        bubble     = redirect || (state == ST_SQUASH && !stall);
        fd_flush   = bubble;
        fd_en      = !stall && (state != ST_SQUASH);
        fd_d_instr = (state == ST_HOLD) ? hold_instr : q_imem;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_SQUASH;
            pc           <= RESET_PC;
            req_pc       <= RESET_PC;
            hold_instr   <= NOP_WORD;
            bubble_count <= '0;
        end else begin
            if (bubble && bubble_count != 16'hFFFF)
                bubble_count <= bubble_count + 16'd1;

            if (redirect) begin
                pc         <= redirect_target;
                hold_instr <= NOP_WORD;
                state      <= ST_SQUASH;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (stall) begin
                            hold_instr <= q_imem;
                            state      <= ST_HOLD;
                        end else begin
                            req_pc <= pc;
                            pc     <= pc + 12'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            req_pc <= pc;
                            pc     <= pc + 12'd1;
                            state  <= ST_RUN;
                        end
                    end
                    ST_SQUASH: begin
                        if (!stall) begin
                            req_pc <= pc;
                            pc     <= pc + 12'd1;
                            state  <= ST_RUN;
                        end
                    end
                    default: state <= ST_SQUASH;
                endcase
            end
        end
    end

    assign address_imem = pc;

    fd_latch #(
        .NOP_WORD (NOP_WORD)
    ) u_fd_latch (
        .clock   (clock),
        .reset   (reset),
        .en      (fd_en),
        .flush   (fd_flush),
        .d_instr (fd_d_instr),
        .d_next  (req_pc + 12'd1),
        .q_instr (q_imem_fd),
        .q_next  (next_iaddr_fd)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a synchronous imem whose word at address a is 0x1000_0000+a.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] q_imem;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_target = 12'h000;
    logic [11:0] address_imem;
    logic [31:0] q_imem_fd;
    logic [11:0] next_iaddr_fd;
    logic [15:0] bubble_count;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .q_imem          (q_imem),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .address_imem    (address_imem),
        .q_imem_fd       (q_imem_fd),
        .next_iaddr_fd   (next_iaddr_fd),
        .bubble_count    (bubble_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem(input logic [11:0] a);
        return 32'h1000_0000 + {20'h0, a};
    endfunction

    always @(posedge clock) q_imem <= mem(address_imem);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_fd(input string tag, input logic [31:0] ins, input logic [11:0] nxt);
        chk({tag, "_instr"}, q_imem_fd, ins);
        chk({tag, "_next"}, {20'h0, next_iaddr_fd}, {20'h0, nxt});
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clock);
        chk_fd("rst", NOP, 12'h000);
        chk("rst_addr", {20'h0, address_imem}, 32'h0);
        chk("rst_bub", {16'h0, bubble_count}, 32'h0);

        // free run from reset
        reset = 1'b1;
        step(); chk_fd("run0", NOP, 12'h000);
        chk("run0_bub", {16'h0, bubble_count}, 32'd1);
        step(); chk_fd("run1", mem(12'h000), 12'h001);
        chk("run1_addr", {20'h0, address_imem}, 32'd2);
        step(); chk_fd("run2", mem(12'h001), 12'h002);
        step(); chk_fd("run3", mem(12'h002), 12'h003);
        step(); chk_fd("run4", mem(12'h003), 12'h004);
        step(); chk_fd("run5", mem(12'h004), 12'h005);

        // stall three cycles while imem[5] returns
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_fd("stall", mem(12'h004), 12'h005);
            chk("stall_addr", {20'h0, address_imem}, 32'd6);
        end
        stall = 1'b0;
        step(); chk_fd("rel0", mem(12'h005), 12'h006);
        step(); chk_fd("rel1", mem(12'h006), 12'h007);

        // redirect with imem[7] in flight
        redirect = 1'b1; redirect_target = 12'h040;
        step(); chk_fd("rd0", NOP, 12'h000);
        redirect = 1'b0;
        step(); chk_fd("rd1", NOP, 12'h000);
        chk("rd_bub", {16'h0, bubble_count}, 32'd3);
        step(); chk_fd("rd2", mem(12'h040), 12'h041);

        // redirect and stall together while holding
        stall = 1'b1;
        step(); chk_fd("hold", mem(12'h040), 12'h041);
        redirect = 1'b1; redirect_target = 12'h080;
        step(); chk_fd("hrd0", NOP, 12'h000);
        chk("hrd_addr", {20'h0, address_imem}, 32'h080);
        redirect = 1'b0; stall = 1'b0;
        step(); chk_fd("hrd1", NOP, 12'h000);
        step(); chk_fd("hrd2", mem(12'h080), 12'h081);
        chk("hrd_bub", {16'h0, bubble_count}, 32'd5);

        // PC wrap at 0xFFF
        redirect = 1'b1; redirect_target = 12'hFFF;
        step(); redirect = 1'b0;
        step(); chk("wrap_addr", {20'h0, address_imem}, 32'h000);
        step(); chk_fd("wrap0", mem(12'hFFF), 12'h000);
        step(); chk_fd("wrap1", mem(12'h000), 12'h001);

        // stall during squash
        redirect = 1'b1; redirect_target = 12'h100;
        step(); redirect = 1'b0; stall = 1'b1;
        step(); chk_fd("sqst", NOP, 12'h000);
        chk("sqst_addr", {20'h0, address_imem}, 32'h100);
        chk("sqst_bub", {16'h0, bubble_count}, 32'd8);
        stall = 1'b0;
        step(); chk("sq_bub", {16'h0, bubble_count}, 32'd9);
        step(); chk_fd("sq_out", mem(12'h100), 12'h101);

        // bubble counter saturation
        force dut.bubble_count = 16'hFFFE;
        #1 release dut.bubble_count;
        redirect = 1'b1; redirect_target = 12'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sat_bub", {16'h0, bubble_count}, 32'h0000_FFFF);
        end
        redirect = 1'b0;

        // asynchronous reset in the middle of HOLD
        step(); step();
        stall = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk_fd("arst", NOP, 12'h000);
        chk("arst_addr", {20'h0, address_imem}, 32'h0);
        chk("arst_bub", {16'h0, bubble_count}, 32'h0);
        stall = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step(); chk_fd("arst0", NOP, 12'h000);
        step(); chk_fd("arst1", mem(12'h000), 12'h001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
